// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared definitions for the LED/RGB PWM controller
// Register offsets, store-width codes, the CTRL layout and the byte-lane
// helper used by the bus decode in led_pwm_controller.
package led_pwm_pkg;

    localparam logic [3:0] CTRL_OFS  = 4'h0;
    localparam logic [3:0] DUTY_OFS  = 4'h4;
    localparam logic [3:0] PRESC_OFS = 4'h8;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic invert;
        logic enable;
    } ctrl_t;

    // Byte enables for a store; misaligned halfword/word stores and
    // unknown widths produce no enables, so the store is dropped.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] ofs);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            F3_SB: be = 4'b0001 << ofs;
            F3_SH: be = ofs[0] ? 4'b0000 : (4'b0011 << ofs);
            F3_SW: be = (ofs == 2'b00) ? 4'b1111 : 4'b0000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: active duty, compare and pin register
// Optional build macro: LED_PWM_FADE_EN (active duty steps by 1 per wrap).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   enable_i        channel running; when low the pin sits at the off level
//   invert_i        active-low pin polarity
//   load_i          period wrap strobe (tick with cnt == 255)
//   cnt_i [7:0]     shared period counter
//   shadow_i [7:0]  software-written duty
//   pin_o           registered PWM pin
//   busy_o          active duty still fading toward the shadow
module pwm_channel (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       invert_i,
    input  logic       load_i,
    input  logic [7:0] cnt_i,
    input  logic [7:0] shadow_i,
    output logic       pin_o,
    output logic       busy_o
);

    logic [7:0] active_q, active_d;
    logic       pin_q, pin_d;

    always_comb begin
        active_d = active_q;
        // While disabled the active duty tracks the shadow so a re-enable
        // starts immediately with the programmed value.
        if (!enable_i) begin
            active_d = shadow_i;
        end else if (load_i) begin
`ifdef LED_PWM_FADE_EN
            if (active_q < shadow_i) begin
                active_d = active_q + 8'd1;
            end else if (active_q > shadow_i) begin
                active_d = active_q - 8'd1;
            end
`else
            active_d = shadow_i;
`endif
        end
        pin_d = enable_i ? ((cnt_i < active_q) ^ invert_i) : invert_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 8'd0;
            pin_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pin_q    <= pin_d;
        end
    end

    assign pin_o = pin_q;

`ifdef LED_PWM_FADE_EN
    assign busy_o = (active_q != shadow_i);
`else
    assign busy_o = 1'b0;
`endif

endmodule

// File: rtl/led_pwm_controller.sv
// rtl/led_pwm_controller.sv - memory-mapped PWM driver for the LED and RGB pins
// Optional build macro: LED_PWM_FADE_EN (fading duty, CTRL[2] fade_busy).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en           store strobe
//   wr_addr/wr_data store byte address and lane-aligned data
//   funct3          store width (sb/sh/sw)
//   rd_addr         load byte address
//   rd_data         registered load data, valid one cycle after rd_addr
//   led/red/green/blue  PWM pins
// Registers: 0x0 CTRL {fade_busy, invert, enable}, 0x4 DUTY shadow
// {led, red, green, blue}, 0x8 PRESC divider.
module led_pwm_controller
    import led_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  funct3,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    ctrl_t               ctrl_q, ctrl_d;
    logic [31:0]         duty_q, duty_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [31:0]         rd_data_q, rd_data_d;

    logic [31:0] wr_ofs, rd_ofs;
    logic        wr_hit;
    logic [3:0]  be;
    logic [31:0] wmask;
    logic        sel_ctrl, sel_duty, sel_presc;
    logic        presc_wr;
    logic        tick, wrap;
    logic [3:0]  pins, busy;
    logic        fade_busy;

    // Subtracting the base keeps the decode valid for any base address.
    assign wr_ofs = wr_addr - BASE_ADDR;
    assign rd_ofs = rd_addr - BASE_ADDR;
    assign wr_hit = wr_en && (wr_ofs < 32'd12);
    assign be     = wr_hit ? store_be(funct3, wr_ofs[1:0]) : 4'b0000;
    assign wmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign sel_ctrl  = ({wr_ofs[3:2], 2'b00} == CTRL_OFS);
    assign sel_duty  = ({wr_ofs[3:2], 2'b00} == DUTY_OFS);
    assign sel_presc = ({wr_ofs[3:2], 2'b00} == PRESC_OFS);
    assign presc_wr  = sel_presc && (be != 4'b0000);

    assign tick = ctrl_q.enable && (presc_cnt_q == presc_q);
    assign wrap = tick && (cnt_q == 8'hFF);

    always_comb begin
        ctrl_d  = ctrl_q;
        duty_d  = duty_q;
        presc_d = presc_q;
        if (sel_ctrl) begin
            ctrl_d = ctrl_t'((ctrl_q & ~wmask[1:0]) | (wr_data[1:0] & wmask[1:0]));
        end
        if (sel_duty) begin
            duty_d = (duty_q & ~wmask) | (wr_data & wmask);
        end
        if (sel_presc) begin
            presc_d = (presc_q & ~wmask[PRESC_W-1:0])
                    | (wr_data[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
        end
    end

    always_comb begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        cnt_d       = cnt_q;
        if (!ctrl_q.enable || presc_wr || tick) begin
            presc_cnt_d = '0;
        end
        if (!ctrl_q.enable) begin
            cnt_d = 8'd0;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign fade_busy = |busy;

    always_comb begin
        rd_data_d = 32'd0;
        if (rd_ofs < 32'd12) begin
            case ({rd_ofs[3:2], 2'b00})
                CTRL_OFS:  rd_data_d = {29'd0, fade_busy, ctrl_q.invert, ctrl_q.enable};
                DUTY_OFS:  rd_data_d = duty_q;
                PRESC_OFS: rd_data_d = 32'(presc_q);
                default:   rd_data_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            duty_q      <= 32'd0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            cnt_q       <= 8'd0;
            rd_data_q   <= 32'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            duty_q      <= duty_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Channel i takes DUTY byte i: 3 led, 2 red, 1 green, 0 blue. Each
    // channel sees the pre-write shadow at wrap, so a same-cycle DUTY store
    // waits for the following wrap.
    for (genvar i = 0; i < 4; i++) begin : g_ch
        pwm_channel u_ch (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .enable_i (ctrl_q.enable),
            .invert_i (ctrl_q.invert),
            .load_i   (wrap),
            .cnt_i    (cnt_q),
            .shadow_i (duty_q[8*i +: 8]),
            .pin_o    (pins[i]),
            .busy_o   (busy[i])
        );
    end

    assign rd_data = rd_data_q;
    assign led     = pins[3];
    assign red     = pins[2];
    assign green   = pins[1];
    assign blue    = pins[0];

endmodule
